// File: rtl/machine_timer_pkg.sv
// rtl/machine_timer_pkg.sv - register offsets and reset constants for machine_timer
//
// Purpose: shared constants for the machine timer block.
//   MTIMER_OFFSET_*  : word offsets (byte address bits [4:2]) of the mapped registers
//   MTIMECMP_RESET   : reset value of mtimecmp (all ones keeps the timer interrupt low)
package machine_timer_pkg;

  localparam logic [2:0] MTIMER_OFFSET_MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIMER_OFFSET_MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMER_OFFSET_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMER_OFFSET_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MTIMER_OFFSET_MSIP        = 3'd4;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/machine_timer_prescaler.sv
// rtl/machine_timer_prescaler.sv - clock divider producing the mtime increment tick
//
// Purpose: counts 0..TICK_DIVIDE-1 and flags a tick on the last count.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   clear_i  : synchronous clear of the count (tick output still reflects the current count)
//   tick_o   : high in the cycle the count equals TICK_DIVIDE-1
module machine_timer_prescaler #(
  parameter int unsigned TICK_DIVIDE = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [15:0] LAST_COUNT = 16'(TICK_DIVIDE - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign tick_o = (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q + 16'd1;
    if (clear_i || tick_o) begin
      count_d = 16'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - memory-mapped mtime/mtimecmp/msip with interrupt outputs
//
// Purpose: 64-bit machine timer and software-interrupt register behind a
// valid/ready request/response word bus. Optional macro MACHINE_TIMER_SHADOW_EN
// adds a shadow of mtime[63:32] captured on MTIME_LO loads for tear-free reads.
// Ports:
//   clock, reset_n                    : clock, asynchronous active-low reset
//   req_valid/req_ready               : request handshake
//   req_write, req_offset, req_wdata  : store flag, word offset, store data
//   rsp_valid/rsp_ready               : response handshake
//   rsp_rdata, rsp_error              : load data (0 for stores), unmapped-offset flag
//   timer_interrupt                   : registered mtime >= mtimecmp
//   software_interrupt                : msip bit
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int unsigned TICK_DIVIDE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_offset,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q;
  logic        timer_irq_q;
  logic        accept, wr, rd;
  logic        wr_mtime_lo, wr_mtime_hi;
  logic        tick;
  logic [31:0] mtime_hi_rdata;

  assign req_ready   = !rsp_valid_q || rsp_ready;
  assign accept      = req_valid && req_ready;
  assign wr          = accept && req_write;
  assign rd          = accept && !req_write;
  assign wr_mtime_lo = wr && (req_offset == MTIMER_OFFSET_MTIME_LO);
  assign wr_mtime_hi = wr && (req_offset == MTIMER_OFFSET_MTIME_HI);

  // A software write to mtime restarts the prescale period.
  machine_timer_prescaler #(
    .TICK_DIVIDE(TICK_DIVIDE)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_i (wr_mtime_lo || wr_mtime_hi),
    .tick_o  (tick)
  );

`ifdef MACHINE_TIMER_SHADOW_EN
  logic [31:0] shadow_q;

  // Capture the high half alongside the low half being returned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= 32'd0;
    end else if (rd && (req_offset == MTIMER_OFFSET_MTIME_LO)) begin
      shadow_q <= mtime_q[63:32];
    end
  end

  assign mtime_hi_rdata = shadow_q;
`else
  assign mtime_hi_rdata = mtime_q[63:32];
`endif

  always_comb begin
    // Half writes take priority over the tick so no carry crosses halves.
    mtime_d = mtime_q;
    if (wr_mtime_lo) begin
      mtime_d[31:0] = req_wdata;
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = req_wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr) begin
      case (req_offset)
        MTIMER_OFFSET_MTIMECMP_LO: mtimecmp_d[31:0]  = req_wdata;
        MTIMER_OFFSET_MTIMECMP_HI: mtimecmp_d[63:32] = req_wdata;
        MTIMER_OFFSET_MSIP:        msip_d            = req_wdata[0];
        default: ;
      endcase
    end

    rsp_rdata_d = 32'd0;
    if (!req_write) begin
      case (req_offset)
        MTIMER_OFFSET_MTIME_LO:    rsp_rdata_d = mtime_q[31:0];
        MTIMER_OFFSET_MTIME_HI:    rsp_rdata_d = mtime_hi_rdata;
        MTIMER_OFFSET_MTIMECMP_LO: rsp_rdata_d = mtimecmp_q[31:0];
        MTIMER_OFFSET_MTIMECMP_HI: rsp_rdata_d = mtimecmp_q[63:32];
        MTIMER_OFFSET_MSIP:        rsp_rdata_d = {31'd0, msip_q};
        default:                   rsp_rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= MTIMECMP_RESET;
      msip_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_error_q <= (req_offset > MTIMER_OFFSET_MSIP);
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_error          = rsp_error_q;
  assign timer_interrupt    = timer_irq_q;
  assign software_interrupt = msip_q;

endmodule

// File: tb/tb_machine_timer.sv
// tb/tb_machine_timer.sv - randomized self-checking bench for machine_timer
module tb_machine_timer;

  localparam int TD = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_offset = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        timer_interrupt;
  logic        software_interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip;
  logic [31:0] m_shadow;
  int          m_phase;
  logic        m_rv, m_re, m_irq;
  logic [31:0] m_rd;

  machine_timer #(.TICK_DIVIDE(TD)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_offset         (req_offset),
    .req_wdata          (req_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_rdata          (rsp_rdata),
    .rsp_error          (rsp_error),
    .timer_interrupt    (timer_interrupt),
    .software_interrupt (software_interrupt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp    = '1;
    m_msip   = 1'b0;
    m_shadow = 32'd0;
    m_phase  = 0;
    m_rv     = 1'b0;
    m_rd     = 32'd0;
    m_re     = 1'b0;
    m_irq    = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0: return m_mtime[31:0];
`ifdef MACHINE_TIMER_SHADOW_EN
      3'd1: return m_shadow;
`else
      3'd1: return m_mtime[63:32];
`endif
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {31'd0, m_msip};
      default: return 32'd0;
    endcase
  endfunction

  // Effect of one rising edge on the architectural state, from pre-edge values.
  task automatic model_edge(input logic acc);
    logic irq_next;
    logic mtime_written;
    irq_next = (m_mtime >= m_cmp);
    mtime_written = acc && req_write && (req_offset <= 3'd1);
    if (acc) begin
      m_rv = 1'b1;
      m_rd = req_write ? 32'd0 : model_read(req_offset);
      m_re = (req_offset > 3'd4);
      if (!req_write && req_offset == 3'd0) m_shadow = m_mtime[63:32];
    end else if (rsp_ready) begin
      m_rv = 1'b0;
    end
    if (mtime_written) begin
      if (req_offset == 3'd0) m_mtime[31:0] = req_wdata;
      else                    m_mtime[63:32] = req_wdata;
      m_phase = 0;
    end else if (m_phase == TD - 1) begin
      m_mtime = m_mtime + 64'd1;
      m_phase = 0;
    end else begin
      m_phase++;
    end
    if (acc && req_write) begin
      case (req_offset)
        3'd2: m_cmp[31:0]  = req_wdata;
        3'd3: m_cmp[63:32] = req_wdata;
        3'd4: m_msip       = req_wdata[0];
        default: ;
      endcase
    end
    m_irq = irq_next;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rsp_valid"}, rsp_valid, m_rv);
    if (m_rv) begin
      check({tag, ".rsp_rdata"}, rsp_rdata, m_rd);
      check({tag, ".rsp_error"}, rsp_error, m_re);
    end
    check({tag, ".timer_irq"}, timer_interrupt, m_irq);
    check({tag, ".sw_irq"}, software_interrupt, m_msip);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic acc;
    #1;
    acc = req_valid && (!m_rv || rsp_ready);
    check("req_ready", req_ready, (!m_rv || rsp_ready));
    @(posedge clock);
    model_edge(acc);
    #1;
    check_outputs("cyc");
    @(negedge clock);
  endtask

  task automatic bus(input logic w, input logic [2:0] off, input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_offset = off;
    req_wdata  = d;
    rsp_ready  = 1'b1;
    cycle();
    req_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clock);
    @(negedge clock);
    check_outputs("reset_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    do_reset();

    // Free-running count after reset, then load the low half.
    idle(10);
    bus(1'b0, 3'd0, 32'd0);
    idle(1);

    // Compare match rises and falls.
    bus(1'b1, 3'd3, 32'd0);
    bus(1'b1, 3'd2, m_mtime[31:0] + 32'd20);
    idle(80);
    check("irq_after_match", timer_interrupt, 1'b1);
    bus(1'b1, 3'd2, 32'hFFFF_FFFF);
    idle(2);
    check("irq_after_raise_cmp", timer_interrupt, 1'b0);

    // Wrap of mtime from all ones.
    bus(1'b1, 3'd0, 32'hFFFF_FFFE);
    bus(1'b1, 3'd1, 32'hFFFF_FFFF);
    idle(2 * TD + 2);
    bus(1'b0, 3'd1, 32'd0);
    check("wrap_hi_read", rsp_rdata, 32'd0);

    // Software interrupt and unmapped offset.
    bus(1'b1, 3'd4, 32'hFFFF_FFFF);
    check("msip_set", software_interrupt, 1'b1);
    bus(1'b0, 3'd4, 32'd0);
    check("msip_read", rsp_rdata, 32'd1);
    bus(1'b1, 3'd6, 32'h1234_5678);
    check("unmapped_wr_err", rsp_error, 1'b1);
    bus(1'b0, 3'd6, 32'd0);
    check("unmapped_rd_data", rsp_rdata, 32'd0);
    idle(1);

    // Backpressure: response holds, no further acceptance.
    req_valid = 1'b1; req_write = 1'b0; req_offset = 3'd2; rsp_ready = 1'b0;
    cycle(); cycle(); cycle(); cycle();
    check("bp_req_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    idle(2);

    // Tear-free (or not) lo-then-hi read across a carry.
    bus(1'b1, 3'd0, 32'hFFFF_FFFF);
    bus(1'b1, 3'd1, 32'h0000_0001);
    idle(TD - 2);
    bus(1'b0, 3'd0, 32'd0);
    check("shadow_lo", rsp_rdata, 32'hFFFF_FFFF);
    idle(1);
    bus(1'b0, 3'd1, 32'd0);
`ifdef MACHINE_TIMER_SHADOW_EN
    check("shadow_hi", rsp_rdata, 32'd1);
`else
    check("live_hi", rsp_rdata, 32'd2);
`endif
    idle(1);

    // Reset with a pending response.
    req_valid = 1'b1; req_write = 1'b0; req_offset = 3'd0; rsp_ready = 1'b0;
    cycle();
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = $urandom_range(0, 1);
      req_offset = 3'($urandom_range(0, 7));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       req_wdata = m_mtime[31:0] + 32'($urandom_range(0, 30));
        1:       req_wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        default: req_wdata = $urandom;
      endcase
      cycle();
      if (i == 1500) do_reset();
    end

    req_valid = 1'b0;
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
